instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and program loader: accepts instruction fields (opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake, scatters the immediate into the format-specific bit positions, and writes the assembled word into instruction memory at an auto-incrementing address. It is the inverse of the immediate generator in the single-cycle core. It sits between the test/boot host and the instruction memory write port, so programs can be loaded from field-level descriptions.

## Interface
- `ADDR_W`, 10: byte-address width of `mem_addr`.
- `BASE_ADDR`, 0: first write address; value after reset, `addr_clr`, or wrap.
- `DEPTH_WORDS`, 256: number of words in the load window; address wraps after the last word.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept a bundle this cycle.
- `op`  in  7  opcode; also selects the format.
- `rd`, `rs1`, `rs2`  in  5 each  register indices.
- `funct3`  in  3; `funct7`  in  7.
- `imm`  in  32  immediate as a signed byte value (U-type: the final upper value, low 12 bits zero).
- `mem_we`  out  1  write request to instruction memory.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `mem_addr`  out  ADDR_W  byte address of the current write.
- `mem_wdata`  out  32  encoded instruction.
- `addr_clr`  in  1  return the write address to `BASE_ADDR`.
- `err`  out  1  sticky immediate-range error.
- `err_clr`  in  1  clears `err`.
- `wr_count`  out  16  completed writes since reset; saturates at 0xFFFF.

## Operation
- Format from `op`: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 1101111 J; 0110111, 0010111 U; any other opcode is treated as I.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Fields a format does not use are ignored.
- One-entry output register:
  - A bundle is accepted when `in_valid && in_ready`.
  - `in_ready = !mem_we || mem_ready` (combinational pass-through of the drain).
- A write completes when `mem_we && mem_ready`. On completion:
  - `mem_addr` advances by 4.
  - After `BASE_ADDR + 4*(DEPTH_WORDS-1)` it wraps to `BASE_ADDR`.
  - `wr_count` increments.
- `addr_clr` with a completing write: the write uses the current address, then the address becomes `BASE_ADDR`. `addr_clr` never drops a pending word.
- `err_clr` and a new error in the same cycle: `err` stays 1 (set wins).

## Timing
- Reset values: `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `err`=0, `wr_count`=0, `in_ready`=1.
- Latency: a bundle accepted in cycle N is presented with `mem_we`=1 in cycle N+1.
- `mem_we`, `mem_addr` and `mem_wdata` hold stable until `mem_ready`.
- Throughput: one word per cycle while `mem_ready`=1.
- `rst` mid-operation discards the pending word; the write does not occur.

## Configuration
- `IMM_RANGE_CHECK_EN` defined — the immediate must be representable in its format:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
  - A violating bundle is still accepted (handshake unchanged), but it is dropped: no write, address and `wr_count` unchanged. `err` sets the following cycle.
- Macro undefined: no checking; out-of-range bits are silently truncated, and `err` is tied to 0.

## Structure
- Shared package `rv32_pkg`: opcode constants (same names as the core decoder) and a format enum {R, I, S, B, U, J}.
- One combinational sub-module `instr_pack`: fields in → word, format and range-ok out. The top holds the handshake, output register, address counter, `err` and `wr_count`.

## Test plan
- addi x1,x0,5 (op 0010011, rd 1, f3 0, imm 5), `mem_ready`=1 → next cycle `mem_we`=1, `mem_wdata`=0x00500093, `mem_addr`=0x000; then `mem_addr`=0x004, `wr_count`=1.
- sw x2,8(x1) then beq x0,x0,-4 back-to-back → 0x0020A423 at 0x000 and 0xFE000EE3 at 0x004 in consecutive cycles.
- jal x1,2048 → 0x001000EF; lui x5,0x12345000 → 0x123452B7.
- `mem_ready`=0 for 3 cycles with `in_valid` held → `in_ready`=0 and the word stable; on release exactly one write occurs, with no duplicate or loss.
- With `IMM_RANGE_CHECK_EN`: addi imm 4096 → no write, `err`=1, address unchanged; `err_clr` → `err`=0. Without the macro: writes 0x00000093.
- `DEPTH_WORDS`=4: five writes → fifth lands at `BASE_ADDR`; `addr_clr` during the 2nd write → 3rd write at `BASE_ADDR`.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode constants (same names as the core decoder)
// and the instruction-format enum used by the encoder.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // Opcode to format; unknown opcodes are packed as I-type.
  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_REG:                    return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_JAL:                    return FMT_J;
      OP_LUI, OP_AUIPC:          return FMT_U;
      default:                   return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: scatters the immediate into the
// format-specific bit positions and reports whether it fits the format.
// Range checking is built only when IMM_RANGE_CHECK_EN is defined; otherwise
// every immediate is accepted and excess bits are truncated.
module instr_pack
  import rv32_pkg::*;
(
  input  logic [6:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output fmt_e        o_fmt,
  output logic        o_range_ok
);

  assign o_fmt = fmt_of(i_op);

  // Assemble the instruction word for the decoded format.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    o_word = '0;
    case (o_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
      FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_op};
      FMT_U: o_word = {i_imm[31:12], i_rd, i_op};
      FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                       i_rd, i_op};
      default: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be exactly representable in the format's field.
  always_comb begin
    o_range_ok = 1'b1;
    case (o_fmt)
      FMT_I, FMT_S: o_range_ok = (i_imm[31:11] == {21{i_imm[11]}});
      FMT_B:        o_range_ok = (i_imm[31:12] == {20{i_imm[12]}}) && !i_imm[0];
      FMT_J:        o_range_ok = (i_imm[31:20] == {12{i_imm[20]}}) && !i_imm[0];
      FMT_U:        o_range_ok = (i_imm[11:0] == 12'd0);
      default:      o_range_ok = 1'b1;
    endcase
  end
`else
  assign o_range_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder / program loader. Accepts field bundles over a
// valid/ready handshake, packs them via instr_pack into a one-entry output
// register and writes them to instruction memory at an auto-incrementing,
// wrapping byte address. Optional immediate range checking (and the sticky
// err flag) is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              addr_clr,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(BASE_ADDR + 4 * (DEPTH_WORDS - 1));
  localparam logic [ADDR_W-1:0] L_STEP = ADDR_W'(4);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [15:0]       r_wr_count;
  logic              r_clr_pend;

  logic [31:0] w_word;
  fmt_e        w_fmt;
  logic        w_range_ok;
  logic        w_accept;
  logic        w_complete;
  logic        w_keep;

  instr_pack u_pack (
    .i_op       (op),
    .i_rd       (rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct3   (funct3),
    .i_funct7   (funct7),
    .i_imm      (imm),
    .o_word     (w_word),
    .o_fmt      (w_fmt),
    .o_range_ok (w_range_ok)
  );

  assign in_ready   = !r_we || mem_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = r_we && mem_ready;
  // R-type has no immediate, so it is never dropped.
  assign w_keep     = w_range_ok || (w_fmt == FMT_R);

  // Output register: load on accept, empty when the write drains.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we <= w_keep;
      if (w_keep) r_wdata <= w_word;
    end else if (w_complete) begin
      r_we <= 1'b0;
    end
  end

  // Write address: advance/wrap on completion; a clear requested while a word
  // is stalled is deferred so the stalled write keeps its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= L_BASE;
      r_clr_pend <= 1'b0;
    end else if (w_complete) begin
      r_clr_pend <= 1'b0;
      if (addr_clr || r_clr_pend || r_addr == L_LAST) r_addr <= L_BASE;
      else                                            r_addr <= r_addr + L_STEP;
    end else if (addr_clr) begin
      if (r_we) r_clr_pend <= 1'b1;
      else      r_addr     <= L_BASE;
    end
  end

  // Saturating count of completed writes.
  always_ff @(posedge clk) begin
    if (rst)                                  r_wr_count <= '0;
    else if (w_complete && r_wr_count != '1)  r_wr_count <= r_wr_count + 16'd1;
  end

  // Sticky range error; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                     r_err <= 1'b0;
    else if (w_accept && !w_keep) r_err <= 1'b1;
    else if (err_clr)            r_err <= 1'b0;
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan cases followed by
// randomized traffic, checked against a field-level reference model and a
// one-entry expected-write queue.
module tb_instr_encoder;
  import rv32_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        op;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              addr_clr;
  logic              err;
  logic              err_clr;
  logic [15:0]       wr_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .addr_clr(addr_clr), .err(err), .err_clr(err_clr),
    .wr_count(wr_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] q[$];
  int          addr_m;
  int          cnt_m;
  logic        err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic byte ref_fmt(input logic [6:0] o);
    case (o)
      7'b0110011:                         return "R";
      7'b0100011:                         return "S";
      7'b1100011:                         return "B";
      7'b1101111:                         return "J";
      7'b0110111, 7'b0010111:             return "U";
      default:                            return "I";
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input logic [6:0] o, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] regs;
    regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | 32'(o);
    case (ref_fmt(o))
      "R": return regs | (32'(f7) << 25) | (32'(d) << 7);
      "S": return regs | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
      "B": return regs | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                       | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      "U": return (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(o);
      "J": return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                | (32'(d) << 7) | 32'(o);
      default: return ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                    | (32'(d) << 7) | 32'(o);
    endcase
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  function automatic bit ref_ok(input logic [6:0] o, input logic [31:0] im);
    int s;
    s = int'(signed'(im));
    case (ref_fmt(o))
      "R":      return 1'b1;
      "B":      return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      "J":      return (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
      "U":      return (im % 4096) == 0;
      default:  return (s >= -2048) && (s <= 2047);
    endcase
  endfunction
`endif

  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    in_valid = 1'b1;
    op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b0; addr_clr = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); addr_m = 0; cnt_m = 0; err_m = 1'b0;
  endtask

  // One clock: predict at the negedge, check state just after the posedge.
  task automatic tick();
    bit pend, comp, acc, ok;
    @(negedge clk);
    pend = (q.size() != 0);
    comp = pend && mem_ready;
    acc  = in_valid && (!pend || mem_ready);
    check("in_ready", 32'(in_ready), 32'(!pend || mem_ready));
`ifdef IMM_RANGE_CHECK_EN
    ok = ref_ok(op, imm);
`else
    ok = 1'b1;
`endif
    if (comp) begin
      check("wr_data", mem_wdata, q[0]);
      check("wr_addr", 32'(mem_addr), 32'(addr_m));
      void'(q.pop_front());
      if (cnt_m != 65535) cnt_m++;
      addr_m = addr_clr ? 0 : (addr_m + 4) % (4 * DEPTH);
    end else if (addr_clr && !pend) begin
      addr_m = 0;
    end
    if (acc && ok) q.push_back(ref_encode(op, rd, rs1, rs2, funct3, funct7, imm));
    if (acc && !ok)   err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
    @(posedge clk); #1;
    check("mem_we",   32'(mem_we),   32'(q.size() != 0));
    check("wr_count", 32'(wr_count), 32'(cnt_m));
    check("err",      32'(err),      32'(err_m));
    check("mem_addr", 32'(mem_addr), 32'(addr_m));
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};

  initial begin
    logic [31:0]       saved_w;
    logic [ADDR_W-1:0] saved_a;
    int                cnt0;
    int                a0;
    logic [31:0]       r_imm;

    op = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    do_reset();
    check("rst_mem_we",   32'(mem_we),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_wdata",    mem_wdata,     32'h0);
    check("rst_err",      32'(err),      32'h0);
    check("rst_count",    32'(wr_count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // addi x1,x0,5
    mem_ready = 1'b1;
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); tick();
    check("addi_we",   32'(mem_we),   32'h1);
    check("addi_word", mem_wdata,     32'h00500093);
    check("addi_addr", 32'(mem_addr), 32'h0);
    idle(); tick();
    check("addi_next_addr", 32'(mem_addr), 32'h4);
    check("addi_count",     32'(wr_count), 32'h1);

    // sw x2,8(x1) then beq x0,x0,-4 back-to-back
    do_reset(); mem_ready = 1'b1;
    send(OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8); tick();
    check("sw_word", mem_wdata,     32'h0020A423);
    check("sw_addr", 32'(mem_addr), 32'h0);
    send(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC); tick();
    check("beq_we",   32'(mem_we),   32'h1);
    check("beq_word", mem_wdata,     32'hFE000EE3);
    check("beq_addr", 32'(mem_addr), 32'h4);

    // jal x1,2048 ; lui x5,0x12345000
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); tick();
    check("jal_word", mem_wdata, 32'h001000EF);
    send(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000); tick();
    check("lui_word", mem_wdata, 32'h123452B7);
    idle(); tick();

    // Back-pressure: word held stable, exactly one write per bundle
    mem_ready = 1'b0;
    send(OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF); tick();
    saved_w = mem_wdata; saved_a = mem_addr; cnt0 = cnt_m;
    send(OP_REG, 5'd4, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready),  32'h0);
      check("stall_wdata",    mem_wdata,      saved_w);
      check("stall_addr",     32'(mem_addr),  32'(saved_a));
    end
    mem_ready = 1'b1; tick();
    idle(); tick();
    check("stall_count", 32'(wr_count), 32'(cnt0 + 2));

    // Out-of-range immediate
    a0 = addr_m;
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096); tick();
`ifdef IMM_RANGE_CHECK_EN
    check("range_no_write", 32'(mem_we),   32'h0);
    check("range_err",      32'(err),      32'h1);
    check("range_addr",     32'(mem_addr), 32'(a0));
    idle(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("range_err_clr", 32'(err), 32'h0);
    send(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("range_set_wins", 32'(err), 32'h1);
    idle(); err_clr = 1'b1; tick(); err_clr = 1'b0;
`else
    check("trunc_word", mem_wdata,     32'h00000093);
    check("trunc_addr", 32'(mem_addr), 32'(a0));
    idle(); tick();
`endif

    // Wrap after DEPTH words
    do_reset(); mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      tick();
      check("wrap_addr", 32'(mem_addr), 32'((i % DEPTH) * 4));
    end
    idle(); tick();

    // addr_clr during the 2nd write
    do_reset(); mem_ready = 1'b1;
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); tick();
    send(OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); tick();
    check("clr_w2_addr", 32'(mem_addr), 32'h4);
    send(OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); addr_clr = 1'b1; tick();
    addr_clr = 1'b0;
    check("clr_w3_we",   32'(mem_we),   32'h1);
    check("clr_w3_addr", 32'(mem_addr), 32'h0);
    idle(); tick();

    // Reset discards a pending word
    mem_ready = 1'b0;
    send(OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7); tick();
    check("pend_we", 32'(mem_we), 32'h1);
    rst = 1'b1; idle();
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); addr_m = 0; cnt_m = 0; err_m = 1'b0;
    check("rstmid_we",    32'(mem_we),   32'h0);
    check("rstmid_count", 32'(wr_count), 32'h0);
    check("rstmid_addr",  32'(mem_addr), 32'h0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 4)
        0:       r_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        1:       r_imm = $urandom;
        2:       r_imm = $urandom & 32'hFFFFF000;
        default: r_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
      endcase
      send(ops[$urandom % 10], 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), r_imm);
      in_valid  = ($urandom % 4) != 0;
      mem_ready = ($urandom % 10) < 7;
      err_clr   = ($urandom % 16) == 0;
      tick();
    end
    idle(); err_clr = 1'b0; mem_ready = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
